prog_counter: RTL and testbench
===============================

Name: prog_counter

Overview:
- Parametrised successor to the free-running board counter: an N-bit up/down counter with a programmable terminal value (Limit), parallel load, and a clock-enable prescaler.
- Selectable wrap or saturate mode; registered terminal-count flag for cascading.
- Exports the top OUT_W bits of the count for direct connection to LEDR or HEX drivers.
- Instantiated by board-level tops (CLOCK_50 domain) as the common timebase/counter for demos.

Parameters:
- N, 24, count width in bits (N >= OUT_W, N >= 2).
- DIV, 1, prescale divisor; the count steps once per DIV enabled clocks (DIV >= 1).
- OUT_W, 10, width of the Disp output.

Ports:
- Clock  in  1  system clock (CLOCK_50 at top level).
- Resetn  in  1  synchronous active-low reset (KEY[0] at top level).
- En  in  1  count enable; gates the prescaler and stepping.
- Up  in  1  direction: 1 = increment, 0 = decrement.
- Load  in  1  synchronous parallel load.
- D  in  N  load value.
- Limit  in  N  terminal value; the count range is 0..Limit.
- Sat  in  1  mode: 0 = wrap, 1 = saturate.
- Q  out  N  current count.
- Disp  out  OUT_W  Q[N-1:N-OUT_W], combinational from Q.
- Tick  out  1  step strobe (combinational).
- Tc  out  1  registered terminal-count flag.

Behaviour:
- Single clock, all state updated on posedge Clock. Reset is synchronous active-low: Resetn=0 at an edge gives Q=0, prescaler p=0, Tc=0. Tick is forced to 0 while Resetn=0.
- Priority at each edge: Resetn, then Load, then step, then hold.

Prescaler:
- p counts 0..DIV-1 while En=1 and holds while En=0.
- Tick = Resetn & En & ~Load & (p == DIV-1).
- On a Tick edge, p wraps to 0. Load clears p to 0.
- DIV=1: Tick = Resetn & En & ~Load every cycle, and p is constant 0.

Load:
- Q <= min(D, Limit).
- Tc <= 0.
- Takes effect regardless of En or Tick.

Step (Tick=1):
- Up=1, Q < Limit: Q <= Q+1.
- Up=1, Q >= Limit: wrap mode Q <= 0; saturate mode Q <= Limit.
- Up=0, Q > Limit (Limit lowered at runtime): Q <= Limit in both modes.
- Up=0, 0 < Q <= Limit: Q <= Q-1.
- Up=0, Q == 0: wrap mode Q <= Limit; saturate mode Q holds 0.

Tc:
- Tc <= 1 on a step edge where Q was at the boundary in the counting direction (Up=1 with Q >= Limit, or Up=0 with Q == 0), in either mode.
- Otherwise, on any edge, Tc <= 0. Tc is therefore a one-cycle pulse per boundary step.
- In saturate mode Tc re-pulses on every step attempted at the boundary.

Other rules:
- Limit=0: Q stays 0 and Tc pulses on every Tick.
- No latency between Tick and Q: Q shows the new value in the cycle after the Tick edge.
- Tc rises in the same cycle as the wrapped Q.
- Arithmetic is unsigned modulo 2^N. Limit = 2^N-1 with wrap mode behaves as a plain N-bit counter.
- Changes to Up, Sat or Limit take effect at the next edge. No state besides Q, p and Tc.
- Default (Up=1, En=1, Sat=0, Limit=all-ones, DIV=1) must reproduce the legacy free-running counter exactly.

Decomposition:
- Shared package/header counter_defs:
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1.
  - DIR_DOWN = 1'b0, DIR_UP = 1'b1.
  - Helper constant for the prescaler width: clog2(DIV), minimum 1.
- One sub-module, tick_gen (DIV parameter; ports Clock, Resetn, En, Clr, Tick), containing the prescaler.
- prog_counter holds the Q/Tc datapath and the boundary logic.

Test Plan:
- Reset: N=8, DIV=1; count to Q=37, assert Resetn=0 for 1 cycle with En=1 -> Q=0, Tc=0 and Tick=0 at that edge; counting resumes with Q=1 at the next edge.
- Wrap up with prescale: N=8, DIV=4, Limit=9, Sat=0, Up=1, En=1 from Q=0 -> Q steps every 4 cycles 0..9, then 0; Tc high for exactly 1 cycle coincident with Q=0 after 9; Tick is a 1-in-4 duty pulse.
- Saturate down: Sat=1, Up=0, DIV=1, load D=2 -> Q=2,1,0,0,0; Tc=0,0,1,1 on the edges attempting a step below 0.
- Load priority and clamp: Limit=9, Load=1 with D=200 on a Tick cycle -> Q=9 (no step), p=0, Tc=0. Then with En=0 for 10 cycles -> Q stays 9 and Tick stays 0.
- Runtime Limit lowering: Q=50, Up=1, Sat=0, Limit set to 20 -> next step Q=0 with Tc=1. Repeat with Up=0 -> Q=20, Tc=0.
- Legacy equivalence: N=24, DIV=1, Limit=24'hFFFFFF, Up=1, Sat=0, load D=24'hFFFFFE -> Q=FFFFFF, then 000000 with Tc=1; Disp = Q[23:14] throughout.

Source files
------------

// File: rtl/counter_defs.sv
// Shared definitions for the programmable counter block.
// Mode/direction encodings, the datapath action type and the prescaler width helper.
package counter_defs;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // What the count register does at the next edge.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_INC,
        ACT_DEC,
        ACT_ZERO,
        ACT_LIMIT
    } act_e;

    // Prescaler register width; a 1-bit register is kept even for DIV=1.
    function automatic int presc_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: one Tick per DIV enabled clocks.
// Ports: Clock, Resetn (sync, active-low), En, Clr (load clear), Tick (comb strobe).
module tick_gen
    import counter_defs::*;
#(
    parameter int DIV = 1
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam int PW = presc_w(DIV);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;

    // Clr (a load) suppresses the strobe so a load never also steps.
    assign Tick = Resetn & En & ~Clr & (p_q == P_LAST);

    always_comb begin
        p_d = p_q;
        if (Clr) begin
            p_d = '0;
        end else if (En) begin
            if (Tick) begin
                p_d = '0;
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// N-bit up/down counter over 0..Limit with load, wrap/saturate and prescaler.
// Ports: Clock, Resetn, En, Up, Load, D, Limit, Sat in; Q, Disp, Tick, Tc out.
module prog_counter
    import counter_defs::*;
#(
    parameter int N     = 24,
    parameter int DIV   = 1,
    parameter int OUT_W = 10
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [N-1:0]     D,
    input  logic [N-1:0]     Limit,
    input  logic             Sat,
    output logic [N-1:0]     Q,
    output logic [OUT_W-1:0] Disp,
    output logic             Tick,
    output logic             Tc
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic         tc_q;
    logic         tc_d;
    logic         tick;
    act_e         act;

    logic at_top;
    logic above;
    logic at_bot;

    tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .Clock (Clock),
        .Resetn(Resetn),
        .En    (En),
        .Clr   (Load),
        .Tick  (tick)
    );

    assign at_top = (q_q >= Limit);
    assign above  = (q_q > Limit);
    assign at_bot = (q_q == '0);

    // Load and tick are exclusive because tick is gated by ~Load.
    always_comb begin
        act  = ACT_HOLD;
        tc_d = 1'b0;
        unique case (1'b1)
            Load: begin
                act = ACT_LOAD;
            end
            tick: begin
                if (Up == DIR_UP) begin
                    if (at_top) begin
                        tc_d = 1'b1;
                        act  = (Sat == MODE_SAT) ? ACT_LIMIT : ACT_ZERO;
                    end else begin
                        act = ACT_INC;
                    end
                end else begin
                    // Count above a lowered Limit snaps back into range.
                    if (above) begin
                        act = ACT_LIMIT;
                    end else if (at_bot) begin
                        tc_d = 1'b1;
                        act  = (Sat == MODE_SAT) ? ACT_ZERO : ACT_LIMIT;
                    end else begin
                        act = ACT_DEC;
                    end
                end
            end
            default: begin
                act = ACT_HOLD;
            end
        endcase
    end

    always_comb begin
        q_d = q_q;
        unique case (act)
            ACT_LOAD:  q_d = (D > Limit) ? Limit : D;
            ACT_INC:   q_d = q_q + N'(1);
            ACT_DEC:   q_d = q_q - N'(1);
            ACT_ZERO:  q_d = '0;
            ACT_LIMIT: q_d = Limit;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign Q    = q_q;
    assign Disp = q_q[N-1:N-OUT_W];
    assign Tick = tick;
    assign Tc   = tc_q;

endmodule

// File: tb/tb_prog_counter.sv
// Randomized and directed bench for prog_counter against a behavioural model.
// Two instances: N=8/DIV=4/OUT_W=4 (index 0) and N=24/DIV=1/OUT_W=10 (index 1).
module tb_prog_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn;
    logic        en [2];
    logic        up [2];
    logic        ld [2];
    logic        sat[2];
    logic [23:0] d  [2];
    logic [23:0] lim[2];

    logic [7:0]  a_q;
    logic [3:0]  a_disp;
    logic        a_tick;
    logic        a_tc;
    logic [23:0] b_q;
    logic [9:0]  b_disp;
    logic        b_tick;
    logic        b_tc;

    prog_counter #(.N(8), .DIV(4), .OUT_W(4)) u_a (
        .Clock (clk),
        .Resetn(rn),
        .En    (en[0]),
        .Up    (up[0]),
        .Load  (ld[0]),
        .D     (d[0][7:0]),
        .Limit (lim[0][7:0]),
        .Sat   (sat[0]),
        .Q     (a_q),
        .Disp  (a_disp),
        .Tick  (a_tick),
        .Tc    (a_tc)
    );

    prog_counter #(.N(24), .DIV(1), .OUT_W(10)) u_b (
        .Clock (clk),
        .Resetn(rn),
        .En    (en[1]),
        .Up    (up[1]),
        .Load  (ld[1]),
        .D     (d[1]),
        .Limit (lim[1]),
        .Sat   (sat[1]),
        .Q     (b_q),
        .Disp  (b_disp),
        .Tick  (b_tick),
        .Tc    (b_tc)
    );

    int checks = 0;
    int fails  = 0;

    longint unsigned mq [2];
    int              mp [2];
    bit              mtc[2];

    int exp_sq [4] = '{1, 0, 0, 0};
    int exp_stc[4] = '{0, 0, 1, 1};

    task automatic check(input string tag,
                         input longint unsigned obs,
                         input longint unsigned exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic longint unsigned mask_of(input int i);
        return (i == 0) ? 64'hFF : 64'hFF_FFFF;
    endfunction

    function automatic int sh_of(input int i);
        return (i == 0) ? 4 : 14;
    endfunction

    function automatic longint unsigned obs_q(input int i);
        return (i == 0) ? 64'(a_q) : 64'(b_q);
    endfunction

    function automatic longint unsigned obs_disp(input int i);
        return (i == 0) ? 64'(a_disp) : 64'(b_disp);
    endfunction

    function automatic longint unsigned obs_tick(input int i);
        return (i == 0) ? 64'(a_tick) : 64'(b_tick);
    endfunction

    function automatic longint unsigned obs_tc(input int i);
        return (i == 0) ? 64'(a_tc) : 64'(b_tc);
    endfunction

    function automatic bit ref_tick(input int i);
        return rn && en[i] && !ld[i] && (mp[i] == div_of(i) - 1);
    endfunction

    // Model of one clock edge, written from the counting rules.
    function automatic void ref_edge(input int i);
        bit t;
        longint unsigned lv;
        longint unsigned dv;
        t  = ref_tick(i);
        lv = 64'(lim[i]) & mask_of(i);
        dv = 64'(d[i]) & mask_of(i);
        if (!rn) begin
            mq[i] = 0; mp[i] = 0; mtc[i] = 0;
            return;
        end
        if (ld[i]) begin
            mq[i] = (dv < lv) ? dv : lv;
            mp[i] = 0; mtc[i] = 0;
            return;
        end
        mtc[i] = 0;
        if (en[i]) mp[i] = t ? 0 : mp[i] + 1;
        if (!t) return;
        if (up[i]) begin
            mtc[i] = (mq[i] >= lv);
            if (mq[i] < lv) mq[i] = mq[i] + 1;
            else            mq[i] = sat[i] ? lv : 0;
        end else begin
            mtc[i] = (mq[i] == 0);
            if (mq[i] > lv)       mq[i] = lv;
            else if (mq[i] == 0)  mq[i] = sat[i] ? 0 : lv;
            else                  mq[i] = mq[i] - 1;
        end
    endfunction

    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("q%0d", i), obs_q(i), mq[i]);
            check($sformatf("tc%0d", i), obs_tc(i), 64'(mtc[i]));
            check($sformatf("tick%0d", i), obs_tick(i), 64'(ref_tick(i)));
            check($sformatf("disp%0d", i), obs_disp(i), mq[i] >> sh_of(i));
        end
        for (int i = 0; i < 2; i++) ref_edge(i);
        @(posedge clk);
        @(negedge clk);
    endtask

    int ntick;

    initial begin
        rn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b1; up[i] = 1'b1; ld[i] = 1'b0; sat[i] = 1'b0;
            d[i] = '0; lim[i] = 24'(mask_of(i));
            mq[i] = 0; mp[i] = 0; mtc[i] = 0;
        end
        @(negedge clk);
        check("rst_q", 64'(b_q), 0);
        check("rst_tc", 64'(b_tc), 0);
        step();

        // Reset mid-count
        rn = 1'b1;
        repeat (37) step();
        check("cnt37", 64'(b_q), 37);
        rn = 1'b0;
        #1 check("rst_tick", 64'(b_tick), 0);
        step();
        check("rst_q0", 64'(b_q), 0);
        check("rst_tc0", 64'(b_tc), 0);
        rn = 1'b1;
        step();
        check("resume_q1", 64'(b_q), 1);

        // Prescaled wrap on instance 0
        rn = 1'b0;
        step();
        rn = 1'b1;
        lim[0] = 24'd9; up[0] = 1'b1; sat[0] = 1'b0; en[0] = 1'b1;
        ntick = 0;
        repeat (40) begin
            #1 ntick += int'(a_tick);
            step();
        end
        check("wrap_q0", 64'(a_q), 0);
        check("wrap_tc", 64'(a_tc), 1);
        check("wrap_ticks", 64'(ntick), 10);
        step();
        check("wrap_tc_pulse", 64'(a_tc), 0);

        // Saturating count-down on instance 1
        sat[1] = 1'b1; up[1] = 1'b0; ld[1] = 1'b1; d[1] = 24'd2;
        step();
        ld[1] = 1'b0;
        check("sd_load", 64'(b_q), 2);
        for (int k = 0; k < 4; k++) begin
            step();
            check("sd_q", 64'(b_q), 64'(exp_sq[k]));
            check("sd_tc", 64'(b_tc), 64'(exp_stc[k]));
        end

        // Load wins over a tick and clamps to Limit
        for (int k = 0; k < 8 && mp[0] != 3; k++) step();
        #1 check("pre_tick", 64'(a_tick), 1);
        ld[0] = 1'b1; d[0] = 24'd200;
        step();
        ld[0] = 1'b0;
        check("clamp_q", 64'(a_q), 9);
        check("clamp_tc", 64'(a_tc), 0);
        en[0] = 1'b0;
        repeat (10) begin
            #1 check("hold_tick", 64'(a_tick), 0);
            step();
        end
        check("hold_q", 64'(a_q), 9);
        en[0] = 1'b1;
        repeat (3) step();
        #1 check("p_cleared_tick", 64'(a_tick), 1);
        step();
        check("clamp_wrap_q", 64'(a_q), 0);
        check("clamp_wrap_tc", 64'(a_tc), 1);

        // Limit lowered below the count
        sat[1] = 1'b0; up[1] = 1'b1; lim[1] = 24'hFF_FFFF;
        ld[1] = 1'b1; d[1] = 24'd50;
        step();
        ld[1] = 1'b0; lim[1] = 24'd20;
        step();
        check("lower_up_q", 64'(b_q), 0);
        check("lower_up_tc", 64'(b_tc), 1);
        lim[1] = 24'hFF_FFFF; ld[1] = 1'b1; d[1] = 24'd50;
        step();
        ld[1] = 1'b0; lim[1] = 24'd20; up[1] = 1'b0;
        step();
        check("lower_dn_q", 64'(b_q), 20);
        check("lower_dn_tc", 64'(b_tc), 0);

        // Legacy free-running rollover
        up[1] = 1'b1; sat[1] = 1'b0; lim[1] = 24'hFF_FFFF;
        ld[1] = 1'b1; d[1] = 24'hFF_FFFE;
        step();
        ld[1] = 1'b0;
        check("leg_q0", 64'(b_q), 64'hFF_FFFE);
        check("leg_disp0", 64'(b_disp), 64'h3FF);
        step();
        check("leg_q1", 64'(b_q), 64'hFF_FFFF);
        check("leg_tc1", 64'(b_tc), 0);
        step();
        check("leg_q2", 64'(b_q), 0);
        check("leg_tc2", 64'(b_tc), 1);
        check("leg_disp2", 64'(b_disp), 0);

        // Random traffic
        repeat (600) begin
            rn = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < 2; i++) begin
                en[i]  = ($urandom_range(0, 3) != 0);
                up[i]  = $urandom_range(0, 1) == 1;
                ld[i]  = ($urandom_range(0, 11) == 0);
                sat[i] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 1) == 1)
                    d[i] = 24'($urandom_range(0, 15));
                else
                    d[i] = 24'(64'($urandom) & mask_of(i));
                case ($urandom_range(0, 5))
                    0: lim[i] = 24'($urandom_range(0, 12));
                    1: lim[i] = 24'(64'($urandom) & mask_of(i));
                    2: lim[i] = 24'(mask_of(i));
                    default: lim[i] = lim[i];
                endcase
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
